// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W_DEF   = 4;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2,
        HALT  = 2'd3
    } state_e;

    // True in the states where the pipe waits on a memory refill.
    function automatic logic is_miss(state_e s);
        return (s == IMISS) || (s == DMISS);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline status in / pipeline-register controls out of the hazard controller.
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic [REG_W-1:0] ifid_src1;
    logic [REG_W-1:0] ifid_src2;
    logic             ifid_use1;
    logic             ifid_use2;
    logic             idex_memread;
    logic [REG_W-1:0] idex_dst;
    logic             br_taken_id;
    logic             imem_miss;
    logic             imem_ready;
    logic             dmem_miss;
    logic             dmem_ready;
    logic             halt_wb;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_nop;
    logic             pipe_we;
    logic             memwb_nop;
    logic             halted;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ifid_src1, ifid_src2, ifid_use1, ifid_use2, idex_memread, idex_dst,
               br_taken_id, imem_miss, imem_ready, dmem_miss, dmem_ready, halt_wb,
        input  pc_we, ifid_we, ifid_flush, idex_nop, pipe_we, memwb_nop, halted,
               err_timeout, stall_cycles
    );

    modport slave (
        input  ifid_src1, ifid_src2, ifid_use1, ifid_use2, idex_memread, idex_dst,
               br_taken_id, imem_miss, imem_ready, dmem_miss, dmem_ready, halt_wb,
        output pc_we, ifid_we, ifid_flush, idex_nop, pipe_we, memwb_nop, halted,
               err_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear wins over enable; hold once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central hazard/stall controller: load-use stalls, branch squash, I/D miss sequencing, halt.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_e           state;
    state_e           state_next;
    logic             load_use;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_nop;
    logic             pipe_we;
    logic             memwb_nop;
    logic             halted;
    logic             in_miss;
    logic             tmr_clr;
    logic             err_set;
    logic             err_timeout;
    logic [TMR_W-1:0] tmr_count;
    logic [CNT_W-1:0] stall_count;

    // Load-use hazard against the load sitting in ID/EX; register 0 never conflicts.
    always_comb begin
        load_use = bus.idex_memread && (bus.idex_dst != REG_W'(0)) &&
                   ((bus.ifid_use1 && (bus.ifid_src1 == bus.idex_dst)) ||
                    (bus.ifid_use2 && (bus.ifid_src2 == bus.idex_dst)));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and same-cycle pipeline-register controls.
    always_comb begin
        state_next = state;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_nop   = 1'b0;
        pipe_we    = 1'b1;
        memwb_nop  = 1'b0;
        halted     = 1'b0;

        case (state)
            RUN: begin
                if (bus.halt_wb)        state_next = HALT;
                else if (bus.dmem_miss) state_next = DMISS;
                else if (bus.imem_miss) state_next = IMISS;
                if (load_use) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_nop = 1'b1;
                end else if (bus.br_taken_id) begin
                    ifid_flush = 1'b1;
                end
            end
            IMISS: begin
                if (bus.halt_wb)         state_next = HALT;
                else if (bus.dmem_miss)  state_next = DMISS;
                else if (bus.imem_ready) state_next = RUN;
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
            end
            DMISS: begin
                // A still-pending fetch miss is taken straight back up once data returns.
                if (bus.dmem_ready) state_next = bus.imem_miss ? IMISS : RUN;
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                pipe_we   = 1'b0;
                memwb_nop = 1'b1;
            end
            HALT: begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                pipe_we = 1'b0;
                halted  = 1'b1;
            end
            default: state_next = RUN;
        endcase

        if (!rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            pipe_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_nop   = 1'b1;
            memwb_nop  = 1'b1;
            halted     = 1'b0;
        end
    end

    // Miss timer restarts on every state change and only runs inside a miss state.
    always_comb begin
        in_miss = is_miss(state);
        tmr_clr = !in_miss || (state_next != state);
        err_set = in_miss && !tmr_clr && (tmr_count == TMR_W'(TIMEOUT - 1));
    end

    hazard_sat_counter #(.W(TMR_W)) u_miss_timer (
        .clk   (clk),
        .rst_n (rst),
        .en    (in_miss),
        .clr   (tmr_clr),
        .count (tmr_count)
    );

    hazard_sat_counter #(.W(CNT_W)) u_stall_counter (
        .clk   (clk),
        .rst_n (rst),
        .en    (!pc_we && (state != HALT)),
        .clr   (1'b0),
        .count (stall_count)
    );

    // Sticky timeout flag, set on the edge the timer reaches TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_timeout <= 1'b0;
        end else if (err_set) begin
            err_timeout <= 1'b1;
        end
    end

    assign bus.pc_we        = pc_we;
    assign bus.ifid_we      = ifid_we;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_nop     = idex_nop;
    assign bus.pipe_we      = pipe_we;
    assign bus.memwb_nop    = memwb_nop;
    assign bus.halted       = halted;
    assign bus.err_timeout  = err_timeout;
    assign bus.stall_cycles = stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int unsigned REG_W   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 255;

    // Control vector order: pc_we ifid_we ifid_flush idex_nop pipe_we memwb_nop halted
    localparam logic [6:0] C_RESET   = 7'b0011010;
    localparam logic [6:0] C_NORMAL  = 7'b1100100;
    localparam logic [6:0] C_LOADUSE = 7'b0001100;
    localparam logic [6:0] C_BRANCH  = 7'b1110100;
    localparam logic [6:0] C_IMISS   = 7'b0110100;
    localparam logic [6:0] C_DMISS   = 7'b0000010;
    localparam logic [6:0] C_HALT    = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [6:0] ctl();
        return {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_nop,
                bus.pipe_we, bus.memwb_nop, bus.halted};
    endfunction

    task automatic idle_inputs();
        bus.ifid_src1    = '0;
        bus.ifid_src2    = '0;
        bus.ifid_use1    = 1'b0;
        bus.ifid_use2    = 1'b0;
        bus.idex_memread = 1'b0;
        bus.idex_dst     = '0;
        bus.br_taken_id  = 1'b0;
        bus.imem_miss    = 1'b0;
        bus.imem_ready   = 1'b0;
        bus.dmem_miss    = 1'b0;
        bus.dmem_ready   = 1'b0;
        bus.halt_wb      = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_RESET) begin
            n_errors++; $display("FAIL reset_ctl: got %b want %b", ctl(), C_RESET);
        end
        n_checks++;
        if (bus.stall_cycles !== 16'd0 || bus.err_timeout !== 1'b0) begin
            n_errors++; $display("FAIL reset_regs: stall=%0d err=%b want 0 0", bus.stall_cycles, bus.err_timeout);
        end
        bus.br_taken_id = 1'b1;
        bus.dmem_miss   = 1'b1;
        #1;
        n_checks++;
        if (ctl() !== C_RESET) begin
            n_errors++; $display("FAIL reset_forced: got %b want %b", ctl(), C_RESET);
        end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL) begin
            n_errors++; $display("FAIL reset_release: got %b want %b", ctl(), C_NORMAL);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        bus.idex_memread = 1'b1; bus.idex_dst = 4'd3;
        bus.ifid_src1 = 4'd5; bus.ifid_use1 = 1'b1;
        bus.ifid_src2 = 4'd3; bus.ifid_use2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_LOADUSE) begin
            n_errors++; $display("FAIL loaduse_src2: got %b want %b", ctl(), C_LOADUSE);
        end
        next_cycle();
        bus.idex_memread = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL || bus.stall_cycles !== 16'd1) begin
            n_errors++; $display("FAIL loaduse_bubble: got %b stall=%0d want %b 1", ctl(), bus.stall_cycles, C_NORMAL);
        end
        next_cycle();
        bus.idex_memread = 1'b1; bus.idex_dst = 4'd7;
        bus.ifid_src1 = 4'd7; bus.ifid_use1 = 1'b1; bus.ifid_use2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_LOADUSE) begin
            n_errors++; $display("FAIL loaduse_src1: got %b want %b", ctl(), C_LOADUSE);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL || bus.stall_cycles !== 16'd2) begin
            n_errors++; $display("FAIL loaduse_count: got %b stall=%0d want %b 2", ctl(), bus.stall_cycles, C_NORMAL);
        end
    endtask

    task automatic test_no_hazard();
        apply_reset();
        bus.idex_memread = 1'b1; bus.idex_dst = 4'd0;
        bus.ifid_src1 = 4'd0; bus.ifid_use1 = 1'b1;
        bus.ifid_src2 = 4'd0; bus.ifid_use2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL) begin
            n_errors++; $display("FAIL nohaz_r0: got %b want %b", ctl(), C_NORMAL);
        end
        next_cycle();
        bus.idex_dst = 4'd4; bus.ifid_src1 = 4'd4; bus.ifid_use1 = 1'b0;
        bus.ifid_src2 = 4'd2; bus.ifid_use2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL) begin
            n_errors++; $display("FAIL nohaz_unused: got %b want %b", ctl(), C_NORMAL);
        end
        next_cycle();
        bus.idex_memread = 1'b0; bus.ifid_use1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL) begin
            n_errors++; $display("FAIL nohaz_noload: got %b want %b", ctl(), C_NORMAL);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.stall_cycles !== 16'd0) begin
            n_errors++; $display("FAIL nohaz_count: stall=%0d want 0", bus.stall_cycles);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        bus.br_taken_id = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_BRANCH) begin
            n_errors++; $display("FAIL branch_flush: got %b want %b", ctl(), C_BRANCH);
        end
        next_cycle();
        bus.idex_memread = 1'b1; bus.idex_dst = 4'd6;
        bus.ifid_src1 = 4'd6; bus.ifid_use1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_LOADUSE) begin
            n_errors++; $display("FAIL branch_blocked: got %b want %b", ctl(), C_LOADUSE);
        end
        next_cycle();
        bus.idex_memread = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_BRANCH) begin
            n_errors++; $display("FAIL branch_retry: got %b want %b", ctl(), C_BRANCH);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL || bus.stall_cycles !== 16'd1) begin
            n_errors++; $display("FAIL branch_count: got %b stall=%0d want %b 1", ctl(), bus.stall_cycles, C_NORMAL);
        end
    endtask

    task automatic test_dual_miss();
        apply_reset();
        bus.dmem_miss = 1'b1; bus.imem_miss = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL) begin
            n_errors++; $display("FAIL dual_run: got %b want %b", ctl(), C_NORMAL);
        end
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 5) begin
                bus.dmem_ready = 1'b1; bus.dmem_miss = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (ctl() !== C_DMISS) begin
                n_errors++; $display("FAIL dual_dmiss%0d: got %b want %b", k, ctl(), C_DMISS);
            end
        end
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            bus.dmem_ready = 1'b0;
            if (k == 3) begin
                bus.imem_ready = 1'b1; bus.imem_miss = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (ctl() !== C_IMISS) begin
                n_errors++; $display("FAIL dual_imiss%0d: got %b want %b", k, ctl(), C_IMISS);
            end
        end
        next_cycle();
        bus.imem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL || bus.stall_cycles !== 16'd8 || bus.err_timeout !== 1'b0) begin
            n_errors++; $display("FAIL dual_done: got %b stall=%0d err=%b want %b 8 0",
                                 ctl(), bus.stall_cycles, bus.err_timeout, C_NORMAL);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        bus.dmem_miss = 1'b1;
        for (int k = 1; k <= 258; k++) begin
            next_cycle();
            @(negedge clk);
            if (k == 255) begin
                n_checks++;
                if (bus.err_timeout !== 1'b0) begin
                    n_errors++; $display("FAIL timeout_early: err=%b want 0", bus.err_timeout);
                end
            end
            if (k == 256) begin
                n_checks++;
                if (bus.err_timeout !== 1'b1 || ctl() !== C_DMISS || bus.stall_cycles !== 16'd255) begin
                    n_errors++; $display("FAIL timeout_set: err=%b ctl=%b stall=%0d want 1 %b 255",
                                         bus.err_timeout, ctl(), bus.stall_cycles, C_DMISS);
                end
            end
            if (k == 258) begin
                n_checks++;
                if (bus.err_timeout !== 1'b1 || ctl() !== C_DMISS) begin
                    n_errors++; $display("FAIL timeout_sticky: err=%b ctl=%b want 1 %b",
                                         bus.err_timeout, ctl(), C_DMISS);
                end
            end
        end
        next_cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl() !== C_RESET || bus.err_timeout !== 1'b0 || bus.stall_cycles !== 16'd0) begin
            n_errors++; $display("FAIL timeout_reset: ctl=%b err=%b stall=%0d want %b 0 0",
                                 ctl(), bus.err_timeout, bus.stall_cycles, C_RESET);
        end
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        next_cycle();
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL || bus.stall_cycles !== 16'd0) begin
            n_errors++; $display("FAIL timeout_ready_ignored: ctl=%b stall=%0d want %b 0",
                                 ctl(), bus.stall_cycles, C_NORMAL);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        bus.halt_wb = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_NORMAL) begin
            n_errors++; $display("FAIL halt_arrive: got %b want %b", ctl(), C_NORMAL);
        end
        next_cycle();
        bus.halt_wb = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_HALT) begin
            n_errors++; $display("FAIL halt_enter: got %b want %b", ctl(), C_HALT);
        end
        next_cycle();
        bus.dmem_miss = 1'b1; bus.imem_miss = 1'b1; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_HALT) begin
            n_errors++; $display("FAIL halt_ignore: got %b want %b", ctl(), C_HALT);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ctl() !== C_HALT || bus.stall_cycles !== 16'd0) begin
            n_errors++; $display("FAIL halt_absorb: got %b stall=%0d want %b 0", ctl(), bus.stall_cycles, C_HALT);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_dual_miss();
        test_timeout();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
